// File: rtl/alu_pkg.sv
// Shared ALU encodings and widths.
// Used by decode and by the execute-stage ALU share arbiter.
package alu_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_core.sv
// 64-bit execute ALU: ADD/SUB/AND/XOR with signed overflow.
// Overflow is only meaningful for ADD/SUB and reads 0 for logic ops.
import alu_pkg::*;

module alu_core (
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  alu_op_e          op,
    output logic [ALU_W-1:0] y,
    output logic             ovf
);

    logic [ALU_W-1:0] sum;
    logic [ALU_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        unique case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (a[ALU_W-1] == b[ALU_W-1]) &&
                      (sum[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (a[ALU_W-1] != b[ALU_W-1]) &&
                      (diff[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter, search starts after ptr.
// Produces a one-hot grant plus the binary index of the winner.
module alu_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [SRC_W-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 64-bit ALU among NREQ requesters with round-robin fairness,
// registering one result per cycle with source id and Y86 condition codes.
import alu_pkg::*;

module alu_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ALU_W-1:0]      res_value,
    output logic [SRC_W-1:0]      res_src,
    output logic                  res_zf,
    output logic                  res_sf,
    output logic                  res_of
);

    slot_state_e      state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [ALU_W-1:0] value_q, value_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;

    logic             slot_free;
    logic             arb_en;
    logic             grant;
    logic [NREQ-1:0]  gnt;
    logic [SRC_W-1:0] win;
    logic [ALU_W-1:0] alu_y;
    logic             alu_ovf;

    assign slot_free = (state_q == S_EMPTY) || res_ready;
    // rst_n gates the grant so nothing is handshaken while held in reset.
    assign arb_en    = slot_free && rst_n;
    assign grant     = |gnt;

    alu_rr_arbiter #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt),
        .idx (win)
    );

    alu_core u_alu (
        .a   (req_a[ALU_W*win +: ALU_W]),
        .b   (req_b[ALU_W*win +: ALU_W]),
        .op  (alu_op_e'(req_op[2*win +: 2])),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        value_d = value_q;
        src_d   = src_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        unique case (state_q)
            S_EMPTY: if (grant) state_d = S_FULL;
            S_FULL:  if (res_ready && !grant) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
        if (grant) begin
            ptr_d   = win;
            value_d = alu_y;
            src_d   = win;
            zf_d    = (alu_y == '0);
            sf_d    = alu_y[ALU_W-1];
            of_d    = alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            ptr_q   <= SRC_W'(NREQ - 1);
            value_q <= '0;
            src_q   <= '0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            value_q <= value_d;
            src_q   <= src_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
        end
    end

    assign req_ready = gnt;
    assign res_valid = (state_q == S_FULL);
    assign res_value = value_q;
    assign res_src   = src_q;
    assign res_zf    = zf_q;
    assign res_sf    = sf_q;
    assign res_of    = of_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter (NREQ=2).
module tb_alu_share_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_op;
    logic         res_valid;
    logic         res_ready;
    logic [63:0]  res_value;
    logic [0:0]   res_src;
    logic         res_zf;
    logic         res_sf;
    logic         res_of;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(2), .SRC_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_value (res_value),
        .res_src   (res_src),
        .res_zf    (res_zf),
        .res_sf    (res_sf),
        .res_of    (res_of)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [63:0] a0;
        logic [63:0] b0;
        logic [1:0]  op0;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [1:0]  op1;
        logic        rr;
        logic [1:0]  e_rdy;
        logic        e_vld;
        logic [63:0] e_val;
        logic        e_src;
        logic        e_zf;
        logic        e_sf;
        logic        e_of;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld,
                         input logic [63:0] a0, input logic [63:0] b0,
                         input logic [1:0] op0,
                         input logic [63:0] a1, input logic [63:0] b1,
                         input logic [1:0] op1, input logic rr);
        req_valid = vld;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        res_ready = rr;
    endtask

    task automatic check_res(input string tag, input logic v,
                             input logic [63:0] val, input logic s,
                             input logic zf, input logic sf,
                             input logic of);
        check({tag, ".valid"}, 64'(res_valid), 64'(v));
        if (v) begin
            check({tag, ".value"}, res_value, val);
            check({tag, ".src"}, 64'(res_src), 64'(s));
            check({tag, ".cc"}, 64'({res_zf, res_sf, res_of}),
                  64'({zf, sf, of}));
        end
    endtask

    initial begin
        // idx: vld a0 b0 op0 a1 b1 op1 rr | rdy vld val src zf sf of
        tv[0]  = '{2'b01, 64'd5, 64'd7, 2'b00, 64'd0, 64'd0, 2'b00, 1'b1,
                   2'b01, 1'b1, 64'd12, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{2'b10, 64'd0, 64'd0, 2'b00,
                   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1,
                   2'b10, 1'b1, 64'h8000_0000_0000_0000, 1'b1,
                   1'b0, 1'b1, 1'b1};
        tv[2]  = '{2'b10, 64'd0, 64'd0, 2'b00, 64'd9, 64'd9, 2'b01, 1'b1,
                   2'b10, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{2'b10, 64'd0, 64'd0, 2'b00, '1, '1, 2'b11, 1'b1,
                   2'b10, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{2'b01, 64'hFFFF_0000_FFFF_0000,
                   64'hFF00_FF00_FF00_FF00, 2'b10,
                   64'd0, 64'd0, 2'b00, 1'b1,
                   2'b01, 1'b1, 64'hFF00_0000_FF00_0000, 1'b0,
                   1'b0, 1'b1, 1'b0};
        tv[5]  = '{2'b10, 64'd0, 64'd0, 2'b00,
                   64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1,
                   2'b10, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
                   1'b0, 1'b0, 1'b1};
        tv[6]  = '{2'b00, 64'd0, 64'd0, 2'b00, 64'd0, 64'd0, 2'b00, 1'b1,
                   2'b00, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b1,
                   2'b01, 1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b1,
                   2'b10, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b1,
                   2'b01, 1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b1,
                   2'b10, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(2'b11, 64'd1, 64'd1, 2'b00, 64'd2, 64'd2, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset.req_ready", 64'(req_ready), 64'd0);
        check("reset.valid", 64'(res_valid), 64'd0);
        check("reset.value", res_value, 64'd0);
        check("reset.src_cc", 64'({res_src, res_zf, res_sf, res_of}), 64'd0);

        @(negedge clk);
        drive(2'b00, 64'd0, 64'd0, 2'b00, 64'd0, 64'd0, 2'b00, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].vld, tv[i].a0, tv[i].b0, tv[i].op0,
                  tv[i].a1, tv[i].b1, tv[i].op1, tv[i].rr);
            #1;
            check($sformatf("v%0d.req_ready", i), 64'(req_ready),
                  64'(tv[i].e_rdy));
            @(posedge clk);
            #1;
            check_res($sformatf("v%0d", i), tv[i].e_vld, tv[i].e_val,
                      tv[i].e_src, tv[i].e_zf, tv[i].e_sf, tv[i].e_of);
        end

        // Backpressure: slot holds src1 result 7, both requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b0);
            #1;
            check($sformatf("bp%0d.req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            check_res($sformatf("bp%0d", c), 1'b1, 64'd7, 1'b1,
                      1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(2'b11, 64'd40, 64'd2, 2'b01, 64'd10, 64'd3, 2'b01, 1'b1);
        #1;
        check("bp_release.req_ready", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1;
        check_res("bp_release", 1'b1, 64'd38, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset between edges while FULL (ptr currently 0).
        @(negedge clk);
        drive(2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset.valid", 64'(res_valid), 64'd0);
        check("areset.value", res_value, 64'd0);
        check("areset.req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        drive(2'b11, 64'd1, 64'd1, 2'b00, 64'd10, 64'd3, 2'b01, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("post%0d.req_ready", c), 64'(req_ready),
                  (c % 2 == 0) ? 64'b01 : 64'b10);
            @(posedge clk);
            #1;
            check_res($sformatf("post%0d", c), 1'b1,
                      (c % 2 == 0) ? 64'd2 : 64'd7, 1'(c % 2),
                      1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
